hpdl_refresh_ctrl: RTL and testbench

Sequencer that continuously copies the 16-byte display buffer into four HPDL-1414 chips. It owns the buffer's read port and generates the caret blink strobe. It also produces the per-chip write cycles (data and digit address with setup, WR low time and hold) required by the displays. It sits between the display buffer memory and the Pmod pins; the UART/host side keeps exclusive use of the buffer's write port.

---
 rtl/hpdl_pkg.sv | 20 ++
 rtl/hpdl_refresh_ctrl_if.sv | 27 ++
 rtl/hpdl_char_map.sv | 27 ++
 rtl/hpdl_refresh_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hpdl_refresh_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hpdl_pkg.sv
// Shared types and constants for the HPDL-1414 refresh sequencer.
package hpdl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam int DISPLAY_CHARS  = 16;
    localparam int CHARS_PER_CHIP = 4;

    localparam logic [7:0] SPACE_CHR = 8'h20;
    localparam logic [7:0] CHR_MIN   = 8'h20;
    localparam logic [7:0] CHR_MAX   = 8'h5F;

endpackage

// File: rtl/hpdl_refresh_ctrl_if.sv
// Buffer read port, caret strobe and HPDL pin bus of the refresh sequencer.
interface hpdl_refresh_ctrl_if;

    logic       i_enable;
    logic       o_rd_en;
    logic [3:0] o_rd_addr;
    logic [7:0] i_rd_data;
    logic       o_caret_strobe;
    logic [6:0] o_disp_data;
    logic [1:0] o_disp_addr;
    logic [3:0] o_disp_wr_n;
    logic       o_busy;
    logic       o_frame_done;

    modport master (
        input  i_enable, i_rd_data,
        output o_rd_en, o_rd_addr, o_caret_strobe,
        output o_disp_data, o_disp_addr, o_disp_wr_n, o_busy, o_frame_done
    );

    modport slave (
        output i_enable, i_rd_data,
        input  o_rd_en, o_rd_addr, o_caret_strobe,
        input  o_disp_data, o_disp_addr, o_disp_wr_n, o_busy, o_frame_done
    );

endinterface

// File: rtl/hpdl_char_map.sv
// Combinational character map from buffer bytes to HPDL-1414 codes.
// Optional macro HPDL_LOWERCASE_FOLD_EN folds a..z onto A..Z.
module hpdl_char_map
    import hpdl_pkg::*;
(
    input  logic [7:0] i_chr,
    output logic [6:0] o_chr
);

    logic [7:0] folded;

    // Drop bit 7, optionally fold lower case, then clamp to the displayable range.
    always_comb begin
        folded = i_chr & 8'h7F;
`ifdef HPDL_LOWERCASE_FOLD_EN
        if (folded >= 8'h61 && folded <= 8'h7A) begin
            folded = folded - 8'h20;
        end
`endif
        if (folded >= CHR_MIN && folded <= CHR_MAX) begin
            o_chr = folded[6:0];
        end else begin
            o_chr = SPACE_CHR[6:0];
        end
    end

endmodule

// File: rtl/hpdl_refresh_ctrl.sv
// Refresh sequencer: copies the 16-byte display buffer into four HPDL-1414
// chips once per refresh tick and generates the caret blink strobe.
// Optional macro HPDL_LOWERCASE_FOLD_EN (in hpdl_char_map) folds lower case.
module hpdl_refresh_ctrl
    import hpdl_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int REFRESH_DIV  = CLK_HZ / 1000,
    parameter int SETUP_CYCLES = 2,
    parameter int WR_CYCLES    = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    hpdl_refresh_ctrl_if.master bus
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [3:0]       SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0]       WR_LAST    = 4'(WR_CYCLES - 1);
    localparam logic [3:0]       HOLD_LAST  = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX   = 4'(DISPLAY_CHARS - 1);

    state_t           state_q, state_d;
    logic [3:0]       index_q, index_d;
    logic [3:0]       ph_cnt_q, ph_cnt_d;
    logic [1:0]       chip_q, chip_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pending_q, pending_d;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic             caret_q, caret_d;
    logic             rd_en_q, rd_en_d;
    logic [3:0]       rd_addr_q, rd_addr_d;
    logic [6:0]       disp_data_q, disp_data_d;
    logic [1:0]       disp_addr_q, disp_addr_d;
    logic [3:0]       wr_n_q, wr_n_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic       tick;
    logic       start;
    logic       abort;
    logic       frame_end;
    logic [6:0] mapped;

    hpdl_char_map u_char_map (
        .i_chr (bus.i_rd_data),
        .o_chr (mapped)
    );

    // Refresh divider, one-deep pending tick (tick beats a same-cycle clear) and caret blink.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        pending_d = pending_q;
        if (tick) begin
            pending_d = 1'b1;
        end else if (start || abort) begin
            pending_d = 1'b0;
        end
        frm_cnt_d = frm_cnt_q;
        caret_d   = caret_q;
        if (frame_end) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d = '0;
                caret_d   = ~caret_q;
            end else begin
                frm_cnt_d = frm_cnt_q + FRM_W'(1);
            end
        end
    end

    // Character sequencer; outputs are registered from the next state so they align with it.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        ph_cnt_d    = ph_cnt_q;
        chip_d      = chip_q;
        disp_data_d = disp_data_q;
        disp_addr_d = disp_addr_q;
        start       = 1'b0;
        abort       = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q && bus.i_enable) begin
                    start   = 1'b1;
                    index_d = '0;
                    state_d = READ;
                end
            end
            READ: state_d = LATCH;
            LATCH: begin
                disp_data_d = mapped;
                disp_addr_d = ~index_q[1:0];
                chip_d      = index_q[3:2];
                ph_cnt_d    = '0;
                state_d     = SETUP;
            end
            SETUP: begin
                if (ph_cnt_q == SETUP_LAST) begin
                    ph_cnt_d = '0;
                    state_d  = STROBE;
                end else begin
                    ph_cnt_d = ph_cnt_q + 4'd1;
                end
            end
            STROBE: begin
                if (ph_cnt_q == WR_LAST) begin
                    ph_cnt_d = '0;
                    state_d  = HOLD;
                end else begin
                    ph_cnt_d = ph_cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (ph_cnt_q == HOLD_LAST) begin
                    ph_cnt_d = '0;
                    if (index_q == LAST_IDX) begin
                        frame_end = 1'b1;
                        state_d   = IDLE;
                    end else if (!bus.i_enable) begin
                        abort   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = READ;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        rd_en_d      = (state_d == READ);
        rd_addr_d    = index_d;
        wr_n_d       = (state_d == STROBE) ? ~(4'b0001 << chip_d) : 4'hF;
        busy_d       = (state_d != IDLE);
        frame_done_d = frame_end;
    end

    // State and output registers; reset forces WR high at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            index_q      <= '0;
            ph_cnt_q     <= '0;
            chip_q       <= '0;
            div_cnt_q    <= '0;
            pending_q    <= 1'b0;
            frm_cnt_q    <= '0;
            caret_q      <= 1'b1;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            disp_data_q  <= SPACE_CHR[6:0];
            disp_addr_q  <= '0;
            wr_n_q       <= 4'hF;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            ph_cnt_q     <= ph_cnt_d;
            chip_q       <= chip_d;
            div_cnt_q    <= div_cnt_d;
            pending_q    <= pending_d;
            frm_cnt_q    <= frm_cnt_d;
            caret_q      <= caret_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            disp_data_q  <= disp_data_d;
            disp_addr_q  <= disp_addr_d;
            wr_n_q       <= wr_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.o_rd_en        = rd_en_q;
    assign bus.o_rd_addr      = rd_addr_q;
    assign bus.o_caret_strobe = caret_q;
    assign bus.o_disp_data    = disp_data_q;
    assign bus.o_disp_addr    = disp_addr_q;
    assign bus.o_disp_wr_n    = wr_n_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_frame_done   = frame_done_q;

endmodule

// File: tb/tb_hpdl_refresh_ctrl.sv
// Testbench for hpdl_refresh_ctrl: buffer model, WR-pulse monitor and frame checks.
module tb_hpdl_refresh_ctrl;

    localparam int REFRESH_DIV = 400;
    localparam int T_SETUP     = 2;
    localparam int T_WR        = 4;
    localparam int T_HOLD      = 2;
    localparam int BLINK       = 3;
    localparam int CHAR_CYC    = 2 + T_SETUP + T_WR + T_HOLD;

`ifdef HPDL_LOWERCASE_FOLD_EN
    localparam logic [6:0] LC_A = 7'h41;
    localparam logic [6:0] LC_Z = 7'h5A;
`else
    localparam logic [6:0] LC_A = 7'h20;
    localparam logic [6:0] LC_Z = 7'h20;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hpdl_refresh_ctrl_if bus();

    hpdl_refresh_ctrl #(
        .REFRESH_DIV  (REFRESH_DIV),
        .SETUP_CYCLES (T_SETUP),
        .WR_CYCLES    (T_WR),
        .HOLD_CYCLES  (T_HOLD),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Display buffer: synchronous read, data valid the cycle after o_rd_en.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference character map written from the rules: strip bit 7, fold, clamp.
    function automatic logic [6:0] cmap(logic [7:0] b);
        int v = int'(b & 8'h7F);
`ifdef HPDL_LOWERCASE_FOLD_EN
        if (v >= 'h61 && v <= 'h7A) v = v - 32;
`endif
        if (v < 'h20 || v > 'h5F) v = 'h20;
        return v[6:0];
    endfunction

    typedef struct { logic [7:0] din; logic [6:0] exp; } vec_t;
    vec_t tbl [16];

    typedef struct { logic [3:0] wr_n; logic [1:0] addr; logic [6:0] data; int width; } wr_t;
    wr_t wrs [$];

    bit         mon_en     = 1'b0;
    int         cyc        = 0;
    int         fall_cyc   = 0;
    int         rise_cyc   = -1000;
    int         chg_cyc    = -1000;
    int         busy_cyc   = 0;
    int         rd_cnt     = 0;
    int         fd_cnt     = 0;
    int         n_frames   = 0;
    logic [3:0] prev_wr_n  = 4'hF;
    logic [8:0] prev_bus   = 9'h020;
    logic       prev_caret = 1'b1;

    // Pin monitor: records each WR pulse and checks setup/hold around it.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            busy_cyc += int'(bus.o_busy);
            rd_cnt   += int'(bus.o_rd_en);
            fd_cnt   += int'(bus.o_frame_done);
            if (bus.o_caret_strobe != prev_caret)
                chk("caret_on_done", int'(bus.o_frame_done), 1);
            if ({bus.o_disp_addr, bus.o_disp_data} != prev_bus) begin
                chk("bus_hold_ok", int'(bus.o_disp_wr_n == 4'hF && prev_wr_n == 4'hF &&
                                        (cyc - rise_cyc) >= T_HOLD), 1);
                chg_cyc = cyc;
            end
            if (prev_wr_n == 4'hF && bus.o_disp_wr_n != 4'hF) begin
                fall_cyc = cyc;
                chk("setup_ok", int'((cyc - chg_cyc) >= T_SETUP), 1);
                chk("one_chip_low", $countones(~bus.o_disp_wr_n), 1);
            end else if (prev_wr_n != 4'hF && bus.o_disp_wr_n == 4'hF) begin
                wrs.push_back('{wr_n: prev_wr_n, addr: bus.o_disp_addr,
                                data: bus.o_disp_data, width: cyc - fall_cyc});
                rise_cyc = cyc;
            end
        end
        prev_wr_n  = bus.o_disp_wr_n;
        prev_bus   = {bus.o_disp_addr, bus.o_disp_data};
        prev_caret = bus.o_caret_strobe;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic arm();
        wrs.delete();
        busy_cyc = 0;
        rd_cnt   = 0;
        fd_cnt   = 0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_rd_en"},      int'(bus.o_rd_en), 0);
        chk({tag, "_rd_addr"},    int'(bus.o_rd_addr), 0);
        chk({tag, "_caret"},      int'(bus.o_caret_strobe), 1);
        chk({tag, "_disp_data"},  int'(bus.o_disp_data), 'h20);
        chk({tag, "_disp_addr"},  int'(bus.o_disp_addr), 0);
        chk({tag, "_wr_n"},       int'(bus.o_disp_wr_n), 'hF);
        chk({tag, "_busy"},       int'(bus.o_busy), 0);
        chk({tag, "_frame_done"}, int'(bus.o_frame_done), 0);
    endtask

    task automatic wait_done(string tag);
        int k = 0;
        step();
        while (!bus.o_frame_done && k < 2000) begin
            step();
            k++;
        end
        chk({tag, "_done_seen"}, int'(bus.o_frame_done), 1);
    endtask

    task automatic check_frame(string tag, bit use_tbl);
        logic [3:0] ew;
        logic [6:0] ed;
        wait_done(tag);
        n_frames++;
        chk({tag, "_busy_cycles"}, busy_cyc, 16 * CHAR_CYC);
        chk({tag, "_reads"}, rd_cnt, 16);
        chk({tag, "_done_pulses"}, fd_cnt, 1);
        chk({tag, "_caret"}, int'(bus.o_caret_strobe), ((n_frames / BLINK) % 2 == 0) ? 1 : 0);
        chk({tag, "_writes"}, wrs.size(), 16);
        for (int i = 0; i < 16 && i < wrs.size(); i++) begin
            ew = ~(4'b0001 << (i / 4));
            ed = use_tbl ? tbl[i].exp : cmap(mem[i]);
            chk($sformatf("%s_w%0d_chip", tag, i),  int'(wrs[i].wr_n), int'(ew));
            chk($sformatf("%s_w%0d_addr", tag, i),  int'(wrs[i].addr), 3 - (i % 4));
            chk($sformatf("%s_w%0d_data", tag, i),  int'(wrs[i].data), int'(ed));
            chk($sformatf("%s_w%0d_width", tag, i), wrs[i].width, T_WR);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int k;
        tbl[0]  = '{8'h1F, 7'h20};  tbl[1]  = '{8'h5F, 7'h5F};
        tbl[2]  = '{8'h60, 7'h20};  tbl[3]  = '{8'hC1, 7'h41};
        tbl[4]  = '{8'h61, LC_A};   tbl[5]  = '{8'h20, 7'h20};
        tbl[6]  = '{8'h41, 7'h41};  tbl[7]  = '{8'h00, 7'h20};
        tbl[8]  = '{8'h7F, 7'h20};  tbl[9]  = '{8'hFF, 7'h20};
        tbl[10] = '{8'hA0, 7'h20};  tbl[11] = '{8'hDF, 7'h5F};
        tbl[12] = '{8'h7A, LC_Z};   tbl[13] = '{8'hE1, LC_A};
        tbl[14] = '{8'h30, 7'h30};  tbl[15] = '{8'h7B, 7'h20};

        bus.i_enable = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h41;
        mon_en = 1'b1;
        repeat (3) step();
        chk_reset_vals("reset");

        // Blank frame: first read exactly one refresh period plus one cycle after release.
        arm();
        rst_n        = 1'b1;
        bus.i_enable = 1'b1;
        k = 0;
        do begin step(); k++; end while (!bus.o_rd_en && k < 2000);
        chk("start_latency", k, REFRESH_DIV + 1);
        check_frame("blank", 1'b0);

        // Character map vectors.
        for (int i = 0; i < 16; i++) mem[i] = tbl[i].din;
        arm();
        check_frame("table", 1'b1);

        // Random buffer contents against the reference map; caret flips after frame 3 and 6.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
            arm();
            check_frame($sformatf("rand%0d", f), 1'b0);
        end

        // Tick while disabled stays pending; enabling starts a frame on the next cycle.
        bus.i_enable = 1'b0;
        arm();
        repeat (REFRESH_DIV + 100) step();
        chk("disabled_no_reads", rd_cnt, 0);
        bus.i_enable = 1'b1;
        step();
        chk("pending_held_start", int'(bus.o_rd_en), 1);
        check_frame("held", 1'b0);

        // Enable drop during the chip-1 pulse of character 5.
        arm();
        k = 0;
        while (!(wrs.size() == 5 && bus.o_disp_wr_n == 4'hD) && k < 2000) begin step(); k++; end
        chk("drop_reached_idx5", int'(bus.o_disp_wr_n), 'hD);
        bus.i_enable = 1'b0;
        repeat (40) step();
        chk("drop_writes", wrs.size(), 6);
        if (wrs.size() == 6) begin
            chk("drop_width", wrs[5].width, T_WR);
            chk("drop_chip",  int'(wrs[5].wr_n), 'hD);
            chk("drop_addr",  int'(wrs[5].addr), 2);
            chk("drop_data",  int'(wrs[5].data), int'(cmap(mem[5])));
        end
        chk("drop_busy_cycles", busy_cyc, 6 * CHAR_CYC);
        chk("drop_reads", rd_cnt, 6);
        chk("drop_no_done", fd_cnt, 0);
        chk("drop_busy_low", int'(bus.o_busy), 0);
        repeat (REFRESH_DIV + 50) step();
        chk("drop_no_more_reads", rd_cnt, 6);

        // Asynchronous reset while chip 2 is strobed.
        bus.i_enable = 1'b1;
        arm();
        k = 0;
        while (bus.o_disp_wr_n != 4'hB && k < 2000) begin step(); k++; end
        chk("rst_reached_strobe", int'(bus.o_disp_wr_n), 'hB);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (3) step();
        n_frames = 0;
        arm();
        mon_en = 1'b1;
        rst_n  = 1'b1;
        k = 0;
        do begin step(); k++; end while (!bus.o_rd_en && k < 2000);
        chk("restart_latency", k, REFRESH_DIV + 1);
        check_frame("post_rst", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
